// File: rtl/program_loader_if.sv
//------------------------------------------------------------------------------
// program_loader_if : receive handshake, memory write port and status bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface program_loader_if #(
   parameter int ADDR_W = 16
);
   logic [7:0]        RX_DATA;
   logic              RX_VALID;
   logic              RX_READY;
   logic              STORE;
   logic [ADDR_W-1:0] ADDRESS;
   logic [7:0]        IO;
   logic              CPU_HALT;
   logic              BUSY;
   logic              DONE;
   logic              ERROR;
   logic [1:0]        ERR_CODE;

   modport master (
      input  RX_DATA, RX_VALID,
      output RX_READY, STORE, ADDRESS, IO, CPU_HALT, BUSY, DONE, ERROR, ERR_CODE
   );

   modport slave (
      output RX_DATA, RX_VALID,
      input  RX_READY, STORE, ADDRESS, IO, CPU_HALT, BUSY, DONE, ERROR, ERR_CODE
   );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
//------------------------------------------------------------------------------
// program_loader : framed byte-stream boot loader feeding the program memory
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module program_loader #(
   parameter int         ADDR_W      = 16,
   parameter int         MAX_ADDR    = 260,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   program_loader_if.master     bus
);
   localparam int c_TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AHI  = 3'd1,
      S_ALO  = 3'd2,
      S_CNT  = 3'd3,
      S_DATA = 3'd4,
      S_CHK  = 3'd5
   } state_t;

   state_t            r_state;
   logic              r_ready;
   logic              r_store;
   logic [ADDR_W-1:0] r_address;
   logic [7:0]        r_io;
   logic              r_halt;
   logic              r_done;
   logic              r_error;
   logic [1:0]        r_err_code;
   logic [7:0]        r_sum;
   logic [7:0]        r_ahi;
   logic [ADDR_W-1:0] r_cur;
   logic [8:0]        r_rem;
   logic [c_TW-1:0]   r_tcnt;

   logic              w_accept;
   logic [7:0]        w_sum;
   logic [8:0]        w_n;
   logic [ADDR_W:0]   w_last;
   logic              w_range_err;
   logic              w_timeout;

   assign w_accept    = bus.RX_VALID & r_ready;
   assign w_sum       = r_sum + bus.RX_DATA;
   assign w_n         = (bus.RX_DATA == 8'd0) ? 9'd256 : {1'b0, bus.RX_DATA};
   // One extra bit so a frame running past the top of the address space is caught
   assign w_last      = {1'b0, r_cur} + (ADDR_W+1)'(w_n) - (ADDR_W+1)'(1);
   assign w_range_err = (w_last > (ADDR_W+1)'(MAX_ADDR));
   assign w_timeout   = (r_state != S_IDLE) && !w_accept &&
                        (r_tcnt == c_TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= S_IDLE;
         r_ready    <= 1'b0;
         r_store    <= 1'b0;
         r_address  <= '0;
         r_io       <= 8'd0;
         r_halt     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_err_code <= 2'd0;
         r_sum      <= 8'd0;
         r_ahi      <= 8'd0;
         r_cur      <= '0;
         r_rem      <= 9'd0;
         r_tcnt     <= '0;
      end else begin
         r_ready <= 1'b1;
         r_store <= 1'b0;
         r_done  <= 1'b0;

         if (r_state == S_IDLE || w_accept)
            r_tcnt <= '0;
         else
            r_tcnt <= r_tcnt + c_TW'(1);

         if (w_timeout) begin
            r_error    <= 1'b1;
            r_err_code <= 2'd3;
            r_state    <= S_IDLE;
         end else if (w_accept) begin
            case (r_state)
               S_IDLE: begin
                  if (bus.RX_DATA == SYNC_BYTE) begin
                     r_state    <= S_AHI;
                     r_halt     <= 1'b1;
                     r_error    <= 1'b0;
                     r_err_code <= 2'd0;
                     r_sum      <= 8'd0;
                  end
               end
               S_AHI: begin
                  r_ahi   <= bus.RX_DATA;
                  r_sum   <= w_sum;
                  r_state <= S_ALO;
               end
               S_ALO: begin
                  r_cur   <= ADDR_W'({r_ahi, bus.RX_DATA});
                  r_sum   <= w_sum;
                  r_state <= S_CNT;
               end
               S_CNT: begin
                  r_sum <= w_sum;
                  r_rem <= w_n;
                  if (w_range_err) begin
                     r_error    <= 1'b1;
                     r_err_code <= 2'd1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
               S_DATA: begin
                  r_store   <= 1'b1;
                  r_io      <= bus.RX_DATA;
                  r_address <= r_cur;
                  r_cur     <= r_cur + ADDR_W'(1);
                  r_sum     <= w_sum;
                  r_rem     <= r_rem - 9'd1;
                  if (r_rem == 9'd1)
                     r_state <= S_CHK;
               end
               S_CHK: begin
                  // Bad checksum leaves the CPU halted; already-written bytes stay
                  if (w_sum == 8'd0) begin
                     r_done <= 1'b1;
                     r_halt <= 1'b0;
                  end else begin
                     r_error    <= 1'b1;
                     r_err_code <= 2'd2;
                  end
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.RX_READY = r_ready;
   assign bus.STORE    = r_store;
   assign bus.ADDRESS  = r_address;
   assign bus.IO       = r_io;
   assign bus.CPU_HALT = r_halt;
   assign bus.BUSY     = (r_state != S_IDLE);
   assign bus.DONE     = r_done;
   assign bus.ERROR    = r_error;
   assign bus.ERR_CODE = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
//------------------------------------------------------------------------------
// tb_program_loader : directed frames with hand-computed expectations
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_program_loader;
   localparam int c_TO = 50000;

   logic CLK = 1'b0;
   logic RST_N;
   int   n_cmp = 0;
   int   n_err = 0;

   program_loader_if #(.ADDR_W(16)) bus ();

   program_loader #(
      .ADDR_W      (16),
      .MAX_ADDR    (260),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (c_TO)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Byte presented before an edge, outputs sampled 1 ns after it; VALID stays high
   task automatic put(input logic [7:0] b);
      bus.RX_DATA  = b;
      bus.RX_VALID = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic gap(input int n);
      bus.RX_VALID = 1'b0;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // {STORE, ADDRESS, IO}
   function automatic logic [31:0] wr();
      return {7'd0, bus.STORE, bus.ADDRESS, bus.IO};
   endfunction

   // {ERROR, ERR_CODE, CPU_HALT, BUSY, DONE}
   function automatic logic [31:0] st();
      return {26'd0, bus.ERROR, bus.ERR_CODE, bus.CPU_HALT, bus.BUSY, bus.DONE};
   endfunction

   initial begin
      bus.RX_DATA  = 8'd0;
      bus.RX_VALID = 1'b0;
      RST_N        = 1'b0;
      #2;
      check("reset_wr",    wr(), 32'h0);
      check("reset_st",    st(), 32'h0);
      check("reset_ready", {31'd0, bus.RX_READY}, 32'd0);
      #20 RST_N = 1'b1;
      gap(2);
      check("ready_after_reset", {31'd0, bus.RX_READY}, 32'd1);

      // Non-SYNC bytes in IDLE are swallowed
      put(8'h00);
      check("idle00", {wr()[24], st()[1]}, 32'h0);
      put(8'h7F);
      check("idle7f", {wr()[24], st()[1]}, 32'h0);

      // Bad checksum frame
      put(8'hA5);
      check("sync_st", st(), {26'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0});
      put(8'h00); put(8'h10); put(8'h03);
      put(8'h11); check("bad_w0", wr(), {7'd0, 1'b1, 16'h0010, 8'h11});
      put(8'h22); check("bad_w1", wr(), {7'd0, 1'b1, 16'h0011, 8'h22});
      put(8'h33); check("bad_w2", wr(), {7'd0, 1'b1, 16'h0012, 8'h33});
      put(8'h99);
      check("bad_chk_st", st(), {26'd0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0});
      check("bad_chk_nostore", {31'd0, bus.STORE}, 32'd0);
      gap(3);
      check("err_sticky", st(), {26'd0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0});

      // Same frame, correct checksum
      put(8'hA5);
      check("resync_clears_err", st(), {26'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0});
      put(8'h00); put(8'h10); put(8'h03); put(8'h11); put(8'h22); put(8'h33);
      put(8'h87);
      check("good_done", st(), {26'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});
      gap(1);
      check("done_pulse_1cyc", {31'd0, bus.DONE}, 32'd0);

      // Frame at 0x100
      put(8'hA5); put(8'h01); put(8'h00); put(8'h03);
      put(8'hAA); check("hi_w0", wr(), {7'd0, 1'b1, 16'h0100, 8'hAA});
      put(8'hBB); check("hi_w1", wr(), {7'd0, 1'b1, 16'h0101, 8'hBB});
      put(8'hCC); check("hi_w2", wr(), {7'd0, 1'b1, 16'h0102, 8'hCC});
      put(8'hCB);
      check("hi_done", st(), {26'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});

      // Range error: 0x104 + 2 - 1 = 0x105 > 260
      gap(1);
      put(8'hA5); put(8'h01); put(8'h04); put(8'h02);
      check("range_st", st(), {26'd0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0});
      put(8'h5A);
      check("range_nostore", {wr()[24], st()[1]}, 32'h0);

      // Boundary accepted: last address exactly 260
      put(8'hA5); put(8'h01); put(8'h03); put(8'h02);
      check("edge_busy", {31'd0, bus.BUSY}, 32'd1);
      put(8'h5A);
      put(8'h5B); check("edge_w1", wr(), {7'd0, 1'b1, 16'h0104, 8'h5B});
      put(8'h45);
      check("edge_done", st(), {26'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});

      // Inter-byte timeout inside DATA
      put(8'hA5); put(8'h00); put(8'h00); put(8'h02);
      put(8'h55); check("to_w0", wr(), {7'd0, 1'b1, 16'h0000, 8'h55});
      gap(c_TO - 1);
      check("to_not_yet", st(), {26'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0});
      gap(1);
      check("to_fired", st(), {26'd0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0});
      check("to_nostore", {31'd0, bus.STORE}, 32'd0);

      // Asynchronous reset mid-DATA
      put(8'hA5); put(8'h00); put(8'h20); put(8'h04);
      put(8'h01); check("pre_rst_w", wr(), {7'd0, 1'b1, 16'h0020, 8'h01});
      #2 RST_N = 1'b0;
      #1;
      check("async_rst_wr", wr(), 32'h0);
      check("async_rst_st", st(), 32'h0);
      check("async_rst_ready", {31'd0, bus.RX_READY}, 32'd0);
      bus.RX_VALID = 1'b0;
      #2 RST_N = 1'b1;
      gap(3);
      put(8'hA5); put(8'h00); put(8'h30); put(8'h01);
      put(8'h77); check("post_rst_w", wr(), {7'd0, 1'b1, 16'h0030, 8'h77});
      put(8'h58);
      check("post_rst_done", st(), {26'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});

      // COUNT=0: 256-byte burst from address 0
      put(8'hA5); put(8'h00); put(8'h00); put(8'h00);
      for (int i = 0; i < 256; i++) begin
         put(8'(i));
         check("burst_w", wr(), {7'd0, 1'b1, 16'(i), 8'(i)});
      end
      put(8'h80);
      check("burst_done", st(), {26'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});
      check("burst_nostore", {31'd0, bus.STORE}, 32'd0);
      gap(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader placed directly upstream of the program memory.
- Accepts framed bytes from a receive source over a valid/ready handshake. Drives the memory write port (STORE, ADDRESS, IO) with the frame's payload.
- Holds the CPU in halt from frame start until a frame completes cleanly.
- Reports DONE or ERROR to the rest of the system.

Parameters:
- ADDR_W, 16, width of ADDRESS output.
- MAX_ADDR, 260, highest writable memory index; frames writing beyond it are rejected.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 50000, maximum idle cycles between bytes inside a frame.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  loader accepts byte; transfer occurs when RX_VALID & RX_READY at a rising CLK edge.
- STORE  out  1  memory write strobe, one cycle per payload byte.
- ADDRESS  out  ADDR_W  memory write address.
- IO  out  8  memory write data.
- CPU_HALT  out  1  CPU hold request.
- BUSY  out  1  high while a frame is in progress (state not IDLE).
- DONE  out  1  one-cycle pulse on a good frame.
- ERROR  out  1  sticky error flag.
- ERR_CODE  out  2  0 none, 1 address range, 2 checksum, 3 timeout.

Behaviour:
- Reset: the clock is CLK and reset is asynchronous active-low RST_N. Asserting RST_N low clears all state immediately, independent of CLK. While RST_N is low: state=IDLE, RX_READY=0, STORE=0, ADDRESS=0, IO=0, CPU_HALT=0, BUSY=0, DONE=0, ERROR=0, ERR_CODE=0.
- RX_READY is 1 in every state after reset deasserts. It is 0 only while RST_N is low.
- Frame format: SYNC, ADDR_HI, ADDR_LO, COUNT, DATA x N, CHK.
  - N = COUNT, except COUNT=0 means N=256.
  - CHK is valid when ADDR_HI+ADDR_LO+COUNT+sum(DATA)+CHK == 0 mod 256.
- States: IDLE, AHI, ALO, CNT, DATA, CHK.
- IDLE:
  - Non-SYNC bytes are accepted and discarded.
  - A SYNC byte moves to AHI, sets CPU_HALT=1, clears ERROR/ERR_CODE, and clears the 8-bit running sum.
- AHI, ALO: capture the start address bytes and add each to the sum.
- CNT:
  - Capture COUNT, add it to the sum, load remaining = N.
  - Range check: if start + N - 1 > MAX_ADDR (computed at ADDR_W+1 bits, no wrap), set ERROR=1, ERR_CODE=1, go to IDLE. No STORE is issued.
  - Otherwise go to DATA.
- DATA:
  - Each accepted byte B at edge k produces STORE=1, IO=B, ADDRESS=current address for exactly the cycle after edge k. STORE latency is 1 cycle.
  - Address then increments and remaining decrements. When remaining reaches 0, go to CHK.
  - Back-to-back bytes on consecutive cycles produce STORE on consecutive cycles.
- CHK:
  - If the sum including CHK equals 0: DONE pulses 1 cycle, CPU_HALT=0, go to IDLE.
  - Otherwise: ERROR=1, ERR_CODE=2, go to IDLE with CPU_HALT held at 1.
  - Memory writes are not rolled back.
- Timeout:
  - In any state other than IDLE, a counter counts cycles without an accepted byte and clears on each accepted byte.
  - When the counter reaches TIMEOUT_CYC: ERROR=1, ERR_CODE=3, go to IDLE, CPU_HALT stays 1.
  - A write already in flight (STORE cycle) still completes.
- CPU_HALT after an error stays 1 until a later frame ends with DONE, or until reset.
- A SYNC byte inside a frame is treated as ordinary data and does not restart the frame.
- ERROR and ERR_CODE hold their values until the next SYNC accepted in IDLE, or until reset.
- Reset asserted mid-frame aborts immediately. STORE drops asynchronously with RST_N, and no partial write strobe is extended.

Test Plan:
- Frame A5 00 10 03 11 22 33 99 (sum 00+10+03+11+22+33=0x79, CHK=0x87; the 99 is deliberately wrong) -> STORE at addresses 0x10, 0x11, 0x12 with data 11, 22, 33 one cycle after each byte; then ERROR=1, ERR_CODE=2, CPU_HALT stays 1. Resend the frame with CHK=87 -> DONE pulse, CPU_HALT=0, ERROR=0.
- Frame A5 01 00 03 AA BB CC CHK to start 0x100 -> writes 0x100..0x102 (the output-register bytes), DONE=1.
- Frame A5 01 04 02 ... (0x104 + 1 = 0x105 > 260) -> no STORE, ERROR=1, ERR_CODE=1, back to IDLE immediately after COUNT.
- Mid-frame gap: send A5 00 00 02 55, then idle TIMEOUT_CYC cycles -> exactly 1 STORE (addr 0, data 55), then ERROR=1, ERR_CODE=3, CPU_HALT=1.
- Bytes 00 7F in IDLE -> no STORE, BUSY=0. Pulse RST_N low mid-DATA -> all outputs 0 without waiting for a CLK edge; next frame loads normally.
- COUNT=0 from address 0 (256 bytes, last address 255 <= 260) -> 256 consecutive STORE cycles with RX_VALID held high, address wraps nothing, DONE with correct CHK.
